// File: rtl/fc_neuron_mac.sv
// Single fully-connected neuron: dot product of one pooled map with external weights,
// plus bias, with saturation and optional ReLU. Two-stage pipeline (multiply, accumulate).
module fc_neuron_mac #(
  parameter int unsigned N    = 16,
  parameter int unsigned Q    = 12,
  parameter int unsigned LEN  = 16,
  parameter int unsigned RELU = 1,
  parameter int unsigned AW   = 4
) (
  input  logic                clk,
  input  logic                master_rst,
  input  logic                ce,
  input  logic                valid_in,
  input  logic signed [N-1:0] din,
  input  logic                end_in,
  output logic [AW-1:0]       w_addr,
  input  logic signed [N-1:0] w_data,
  input  logic signed [N-1:0] bias,
  output logic signed [N-1:0] data_out,
  output logic                valid_out,
  output logic                len_err
);

  localparam int unsigned PW   = 2 * N;
  localparam int unsigned ACCW = 2 * N + $clog2(LEN);
  localparam int unsigned RW   = ACCW + 1;
  localparam logic [AW-1:0] LAST = AW'(LEN - 1);
  localparam logic signed [RW-1:0] SAT_HI = {{(RW - N + 1){1'b0}}, {(N - 1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_LO = {{(RW - N + 1){1'b1}}, {(N - 1){1'b0}}};

  logic [AW-1:0]          cnt;
  logic signed [PW-1:0]   prod;
  logic                   p_v;
  logic                   p_last;
  logic signed [ACCW-1:0] acc;

  logic                   cnt_last_c;
  logic signed [ACCW-1:0] prod_ext_c;
  logic signed [ACCW-1:0] sum_c;
  logic signed [RW-1:0]   biased_c;
  logic signed [RW-1:0]   shifted_c;
  logic signed [N-1:0]    result_c;

  assign w_addr = cnt;

  // Finalisation path: bias alignment, floor shift back to Q, saturate, optional ReLU
  always_comb begin
    cnt_last_c = (cnt == LAST);
    prod_ext_c = ACCW'(prod);
    sum_c      = acc + prod_ext_c;
    biased_c   = RW'(sum_c) + (RW'(bias) <<< Q);
    shifted_c  = biased_c >>> Q;
    if (shifted_c > SAT_HI) begin
      result_c = N'(SAT_HI);
    end else if (shifted_c < SAT_LO) begin
      result_c = N'(SAT_LO);
    end else begin
      result_c = N'(shifted_c);
    end
    if ((RELU != 0) && result_c[N-1]) begin
      result_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (master_rst) begin
      cnt       <= '0;
      prod      <= '0;
      p_v       <= 1'b0;
      p_last    <= 1'b0;
      acc       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      len_err   <= 1'b0;
    end else if (ce) begin
      p_v    <= valid_in;
      p_last <= valid_in & cnt_last_c;
      if (valid_in) begin
        prod <= PW'(din) * PW'(w_data);
        cnt  <= cnt_last_c ? '0 : cnt + AW'(1);
        if (end_in != cnt_last_c) begin
          len_err <= 1'b1;
        end
      end
      valid_out <= 1'b0;
      // Last product of a map: emit result and clear acc so the next map starts clean
      if (p_v) begin
        if (p_last) begin
          acc       <= '0;
          data_out  <= result_c;
          valid_out <= 1'b1;
        end else begin
          acc <= sum_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_fc_neuron_mac.sv
// Bench for fc_neuron_mac: three instances (LEN 4/4/16, ReLU on/off/on) share one stimulus
// stream and are compared every cycle against a dot-product reference model.
module tb_fc_neuron_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, ce, vin, ein;
  logic signed [15:0] din, bias;
  logic signed [15:0] wmem [16];

  logic [3:0]  wa   [3];
  logic [15:0] wd   [3];
  logic [15:0] dout [3];
  logic        vout [3];
  logic        lerr [3];

  assign wd[0] = wmem[wa[0]];
  assign wd[1] = wmem[wa[1]];
  assign wd[2] = wmem[wa[2]];

  fc_neuron_mac #(.N(16), .Q(12), .LEN(4), .RELU(1), .AW(4)) u_len4_relu (
    .clk(clk), .master_rst(rst), .ce(ce), .valid_in(vin), .din(din), .end_in(ein),
    .w_addr(wa[0]), .w_data(wd[0]), .bias(bias), .data_out(dout[0]),
    .valid_out(vout[0]), .len_err(lerr[0]));

  fc_neuron_mac #(.N(16), .Q(12), .LEN(4), .RELU(0), .AW(4)) u_len4_lin (
    .clk(clk), .master_rst(rst), .ce(ce), .valid_in(vin), .din(din), .end_in(ein),
    .w_addr(wa[1]), .w_data(wd[1]), .bias(bias), .data_out(dout[1]),
    .valid_out(vout[1]), .len_err(lerr[1]));

  fc_neuron_mac #(.N(16), .Q(12), .LEN(16), .RELU(1), .AW(4)) u_len16_relu (
    .clk(clk), .master_rst(rst), .ce(ce), .valid_in(vin), .din(din), .end_in(ein),
    .w_addr(wa[2]), .w_data(wd[2]), .bias(bias), .data_out(dout[2]),
    .valid_out(vout[2]), .len_err(lerr[2]));

  int n_chk  = 0;
  int n_fail = 0;
  int ncyc   = 0;

  // Reference model state: sample index, running dot product, finished map awaiting output
  int          lens  [3] = '{4, 4, 16};
  bit          relus [3] = '{1'b1, 1'b0, 1'b1};
  int          m_cnt [3];
  longint      m_run [3];
  bit          m_pend[3];
  longint      m_psum[3];
  bit          m_vout[3];
  logic [15:0] m_dout[3];
  bit          m_lerr[3];

  int          pulse_cyc[$];
  logic [15:0] pulse_val[$];

  function automatic logic [15:0] neuron(input longint s, input logic signed [15:0] b,
                                         input bit relu);
    longint r;
    r = (s + longint'(b) * 64'sd4096) >>> 12;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    if (relu && r < 0) r = 0;
    return 16'(r);
  endfunction

  task automatic chk(input string name, input int inst, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] cycle=%0d got=%h expected=%h", name, inst, ncyc, act, exp);
    end
  endtask

  task automatic model_edge();
    longint prod;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_cnt[i] = 0; m_run[i] = 0; m_pend[i] = 1'b0; m_psum[i] = 0;
        m_vout[i] = 1'b0; m_dout[i] = '0; m_lerr[i] = 1'b0;
      end else if (ce) begin
        m_vout[i] = m_pend[i];
        if (m_pend[i]) m_dout[i] = neuron(m_psum[i], bias, relus[i]);
        m_pend[i] = 1'b0;
        if (vin) begin
          prod = longint'(din) * longint'(wmem[m_cnt[i]]);
          if (ein != (m_cnt[i] == lens[i] - 1)) m_lerr[i] = 1'b1;
          m_run[i] += prod;
          if (m_cnt[i] == lens[i] - 1) begin
            m_pend[i] = 1'b1;
            m_psum[i] = m_run[i];
            m_run[i]  = 0;
            m_cnt[i]  = 0;
          end else begin
            m_cnt[i]++;
          end
        end
      end
    end
  endtask

  // One clock: drive, advance model at the edge, compare on the falling edge
  task automatic cyc(input bit r, input bit c, input bit v, input logic [15:0] d,
                     input bit e);
    rst = r; ce = c; vin = v; din = d; ein = e;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    ncyc++;
    for (int i = 0; i < 3; i++) begin
      chk("valid_out", i, 16'(vout[i]), 16'(m_vout[i]));
      chk("data_out",  i, dout[i], m_dout[i]);
      chk("len_err",   i, 16'(lerr[i]), 16'(m_lerr[i]));
      chk("w_addr",    i, 16'(wa[i]), 16'(m_cnt[i]));
    end
    if (vout[0]) begin
      pulse_cyc.push_back(ncyc);
      pulse_val.push_back(dout[0]);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic feed(input int n, input logic [15:0] d, input bit end_last);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 1'b1, d, end_last && (k == n - 1));
  endtask

  task automatic fill_w(input logic [15:0] w);
    for (int k = 0; k < 16; k++) wmem[k] = w;
  endtask

  task automatic clear_pulses();
    pulse_cyc.delete();
    pulse_val.delete();
  endtask

  typedef struct {
    string       name;
    int          inst;
    int          n;
    logic [15:0] d;
    logic [15:0] w;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[5];

  initial begin
    int c0;
    vt[0] = '{"basic",   0, 4,  16'h1000, 16'h0800, 16'h0000, 16'h2000};
    vt[1] = '{"sat_pos", 2, 16, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF};
    vt[2] = '{"sat_neg", 1, 4,  16'h7FFF, 16'h8000, 16'h0000, 16'h8000};
    vt[3] = '{"relu",    0, 4,  16'h1000, 16'hF000, 16'h0800, 16'h0000};
    vt[4] = '{"norelu",  1, 4,  16'h1000, 16'hF000, 16'h0800, 16'hC800};

    rst = 1'b1; ce = 1'b0; vin = 1'b0; din = '0; ein = 1'b0; bias = '0;
    fill_w(16'h0);

    // Reset state
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("reset_valid", i, 16'(vout[i]), 16'h0);
      chk("reset_data",  i, dout[i], 16'h0);
      chk("reset_lerr",  i, 16'(lerr[i]), 16'h0);
    end

    // Directed maps: result must appear on the cycle after the last sample's edge
    foreach (vt[k]) begin
      cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
      fill_w(vt[k].w);
      bias = vt[k].b;
      feed(vt[k].n, vt[k].d, 1'b1);
      chk({vt[k].name, "_early"}, vt[k].inst, 16'(vout[vt[k].inst]), 16'h0);
      idle(1);
      chk({vt[k].name, "_valid"}, vt[k].inst, 16'(vout[vt[k].inst]), 16'h1);
      chk({vt[k].name, "_data"},  vt[k].inst, dout[vt[k].inst], vt[k].exp);
      chk({vt[k].name, "_lerr"},  vt[k].inst, 16'(lerr[vt[k].inst]), 16'h0);
      idle(1);
      chk({vt[k].name, "_pulse"}, vt[k].inst, 16'(vout[vt[k].inst]), 16'h0);
    end

    // Back-to-back maps
    cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    fill_w(16'h0800); bias = '0;
    clear_pulses();
    feed(4, 16'h1000, 1'b1);
    feed(4, 16'h2000, 1'b1);
    idle(3);
    chk("b2b_count", 0, 16'(pulse_cyc.size()), 16'd2);
    chk("b2b_gap",   0, pulse_cyc.size() == 2 ? 16'(pulse_cyc[1] - pulse_cyc[0]) : 16'hFFFF, 16'd4);
    chk("b2b_val0",  0, pulse_val.size() > 0 ? pulse_val[0] : 16'hDEAD, 16'h2000);
    chk("b2b_val1",  0, pulse_val.size() > 1 ? pulse_val[1] : 16'hDEAD, 16'h4000);

    // Reset drops a partial map
    cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    clear_pulses();
    feed(2, 16'h1000, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    feed(4, 16'h1000, 1'b1);
    idle(3);
    chk("rst_count", 0, 16'(pulse_cyc.size()), 16'd1);
    chk("rst_val",   0, pulse_val.size() > 0 ? pulse_val[0] : 16'hDEAD, 16'h2000);

    // ce=0 mid-map freezes everything; valid_in during the stall must be ignored
    cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    clear_pulses();
    c0 = ncyc + 1;
    feed(2, 16'h1000, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b0);
    feed(2, 16'h1000, 1'b1);
    idle(4);
    chk("ce_count", 0, 16'(pulse_cyc.size()), 16'd1);
    chk("ce_delay", 0, pulse_cyc.size() > 0 ? 16'(pulse_cyc[0] - c0) : 16'hFFFF, 16'd7);
    chk("ce_val",   0, pulse_val.size() > 0 ? pulse_val[0] : 16'hDEAD, 16'h2000);

    // Early end marker: sticky len_err, map still completes on the 4th sample
    cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    clear_pulses();
    feed(2, 16'h1000, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 16'h1000, 1'b1);
    chk("lerr_set", 0, 16'(lerr[0]), 16'h1);
    cyc(1'b0, 1'b1, 1'b1, 16'h1000, 1'b0);
    idle(1);
    chk("lerr_map_val", 0, dout[0], 16'h2000);
    chk("lerr_map_vld", 0, 16'(vout[0]), 16'h1);
    idle(5);
    chk("lerr_sticky", 0, 16'(lerr[0]), 16'h1);
    cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("lerr_clear", 0, 16'(lerr[0]), 16'h0);

    // Randomized traffic against the model
    for (int k = 0; k < 16; k++) wmem[k] = 16'($urandom);
    for (int k = 0; k < 600; k++) begin
      bit r, c, v, e;
      logic [15:0] d;
      if ($urandom_range(0, 9) == 0) wmem[$urandom_range(0, 15)] = 16'($urandom);
      if ($urandom_range(0, 19) == 0) bias = 16'($urandom);
      r = ($urandom_range(0, 149) == 0);
      c = ($urandom_range(0, 4) != 0);
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
      e = (m_cnt[0] == 3) ^ ($urandom_range(0, 24) == 0);
      cyc(r, c, v, d, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
